capture_snaplen: RTL and testbench
==================================

# capture_snaplen

Truncates captured packet copies to a programmable snap length before they reach the capture DMA port. Sits directly downstream of the packet duplicator's capture output (master port 1). Forwards each packet up to the snap length, masks tstrb on the final kept beat and forces tlast there. It then silently consumes the rest of the packet and rewrites the tuser length field to the truncated length. Packets that are not truncated pass through unchanged, with one cycle of latency.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, output data width (bits); tstrb is /8
- C_S_AXIS_DATA_WIDTH, 256, input data width; must equal C_M_AXIS_DATA_WIDTH
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width
- C_S_AXIS_TUSER_WIDTH, 128, input tuser width
- C_S_AXI_DATA_WIDTH, 32, register word width
- NUM_RW_REGS, 1, config register: [15:0] snaplen (bytes), [16] enable
- NUM_RO_REGS, 2, word 0 packets out, word 1 packets truncated
- axi_aclk  in  1  single clock; everything on rising edge
- axi_reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input beat data
- s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  byte enables, contiguous from bit 0
- s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  metadata; [15:0] = packet length in bytes, valid on first beat
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last beat of packet
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  output data
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  output byte enables
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  output metadata
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output last
- rw_regs  in  NUM_RW_REGS*32  config
- rw_defaults  out  NUM_RW_REGS*32  constant 32'h0 (disabled)
- ro_regs  out  NUM_RO_REGS*32  counters

## Operation
- Beat width B = C_M_AXIS_DATA_WIDTH/8 bytes. Bytes in a beat: b = popcount(tstrb).
- Accepted beat = s_axis_tvalid & s_axis_tready.
- States:
  - HEAD: waiting for the first beat.
  - BODY: inside a forwarded packet.
  - DROP: discarding the remainder of a truncated packet.
- HEAD, on accepted beat:
  - Latch S = rw_regs[15:0] and active = rw_regs[16] & (S != 0). These values are used for the whole packet; register writes during a packet have no effect until the next HEAD.
  - Clear the 16-bit byte counter cnt.
  - If active, output tuser = {s_axis_tuser[127:16], min(s_axis_tuser[15:0], S)}; otherwise tuser passes unchanged.
- Non-first beats: tuser passes unchanged.
- Per accepted beat in HEAD/BODY when active (cnt = bytes before this beat):
  - cnt+b < S: forward unchanged. cnt += b. Next state is HEAD if tlast, else BODY.
  - cnt+b >= S: forward with tstrb = (1<<(S-cnt))-1 and tlast=1. If input tlast=1, next state is HEAD; otherwise DROP. Increment the truncated counter only if cnt+b > S or input tlast=0.
  - cnt+b == S with input tlast=1 is not a truncation: tstrb unchanged, truncated counter unchanged.
- Not active: every beat is forwarded verbatim. HEAD/BODY tracking follows tlast.
- DROP:
  - s_axis_tready = 1; beats are accepted and discarded with no output.
  - An accepted tlast beat moves the state to HEAD. The next beat is treated as a new packet head.
- Counters are 32-bit and wrap to 0 after 2^32-1.
  - Packets-out increments on each output handshake with m_axis_tlast=1.
- cnt arithmetic is 17 bits internally, so no overflow with S up to 65535.

## Timing
- One registered output stage; latency 1 cycle from input accept to m_axis_tvalid.
- s_axis_tready = DROP | !m_axis_tvalid | m_axis_tready.
  - This gives full throughput with no bubbles when m_axis_tready=1.
- Output register:
  - Loads on an accepted non-dropped beat.
  - Clears valid on an output handshake when no new beat loads.
- m_axis_* outputs are held stable while tvalid=1 and tready=0.
- Reset values: m_axis_tvalid=0, m_axis_tdata/tstrb/tuser/tlast=0, state=HEAD, cnt=0, counters=0, S=0, active=0.
- Reset mid-packet abandons the packet. The output beat held in the register is dropped, and the first beat after reset is treated as a head.
- A DROP tlast beat followed in the next cycle by a head beat: both accepted, no idle cycle.

## Test plan
- Enable=0, 100-byte packet (4 beats, last tstrb=32'h0000000F):
  - Output identical to input, 1-cycle latency.
  - Packets-out=1, truncated=0.
- S=64, enable=1, 100-byte packet (tuser[15:0]=100):
  - 2 output beats, beat 2 tstrb=32'hFFFFFFFF, tlast=1, tuser[15:0]=64.
  - Beats 3-4 accepted with no output; truncated=1.
- S=40, same packet:
  - Beat 2 tstrb=32'h000000FF, tlast=1, tuser[15:0]=40.
  - Next packet's head is processed normally right after the input tlast.
- S=1500, 60-byte packet:
  - Output unchanged, tuser[15:0]=60, truncated=0.
- S=64 with m_axis_tready toggled pseudo-randomly at 50%, 20 back-to-back 100-byte packets:
  - 40 output beats, no loss or duplication, data held stable under stall.
  - Packets-out=20, truncated=20.
- Assert axi_reset for 1 cycle mid-packet (beat 2 of 4):
  - Next cycle m_axis_tvalid=0 and counters=0.
  - A following 60-byte packet exits intact with tuser[15:0]=60.

Source files
------------

// File: rtl/capture_snaplen.sv
// Truncates capture-path packets to a programmable snap length, rewriting the
// tuser length on the head beat and silently discarding bytes past the snap point.
module capture_snaplen #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXI_DATA_WIDTH   = 32,
   parameter int NUM_RW_REGS          = 1,
   parameter int NUM_RO_REGS          = 2
) (
   input  logic                                      axi_aclk,
   input  logic                                      axi_reset,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]          s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
   input  logic                                      s_axis_tvalid,
   output logic                                      s_axis_tready,
   input  logic                                      s_axis_tlast,

   output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
   output logic                                      m_axis_tvalid,
   input  logic                                      m_axis_tready,
   output logic                                      m_axis_tlast,

   input  logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
   output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_defaults,
   output logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_regs
);

   localparam int unsigned B = C_M_AXIS_DATA_WIDTH / 8;

   localparam logic [1:0] HEAD = 2'd0;
   localparam logic [1:0] BODY = 2'd1;
   localparam logic [1:0] DROP = 2'd2;

   logic [1:0]  state;
   logic [15:0] snap_q;
   logic        active_q;
   logic [15:0] cnt_q;
   logic [31:0] pkts_out;
   logic [31:0] pkts_trunc;

   logic        is_head;
   logic [15:0] snap_eff;
   logic        active_eff;
   logic [15:0] cnt_eff;
   logic [16:0] nbytes;
   logic [16:0] sum;
   logic [16:0] rem;
   logic        reach;
   logic        cut;
   logic        accept;
   logic        fwd;
   logic [B-1:0] strb_mask;
   logic [15:0] len_in;
   logic [C_M_AXIS_TUSER_WIDTH-1:0] user_out;
   logic        unused_rw_bits;

   assign unused_rw_bits = ^rw_regs[NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:17];
   assign rw_defaults    = '0;
   assign ro_regs        = {pkts_trunc, pkts_out};

   assign s_axis_tready = (state == DROP) | ~m_axis_tvalid | m_axis_tready;
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign fwd           = accept & (state != DROP);

   // Head beats take snap/enable straight from the register so the latched copy
   // and the decision for the first beat agree.
   always_comb begin
      is_head    = (state == HEAD);
      snap_eff   = is_head ? rw_regs[15:0] : snap_q;
      active_eff = is_head ? (rw_regs[16] & (|rw_regs[15:0])) : active_q;
      cnt_eff    = is_head ? '0 : cnt_q;

      nbytes = '0;
      for (int unsigned i = 0; i < B; i++)
         nbytes = nbytes + 17'(s_axis_tstrb[i]);

      sum   = {1'b0, cnt_eff} + nbytes;
      rem   = {1'b0, snap_eff} - {1'b0, cnt_eff};
      reach = active_eff & (sum >= {1'b0, snap_eff});
      cut   = reach & ((sum > {1'b0, snap_eff}) | ~s_axis_tlast);

      strb_mask = '0;
      for (int unsigned i = 0; i < B; i++)
         strb_mask[i] = (17'(i) < rem);

      len_in   = s_axis_tuser[15:0];
      user_out = s_axis_tuser;
      if (is_head && active_eff)
         user_out[15:0] = (len_in < snap_eff) ? len_in : snap_eff;
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state         <= HEAD;
         snap_q        <= '0;
         active_q      <= 1'b0;
         cnt_q         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tstrb  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tvalid <= 1'b0;
         pkts_out      <= '0;
         pkts_trunc    <= '0;
      end else begin
         if (fwd) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tstrb  <= cut ? strb_mask : s_axis_tstrb;
            m_axis_tuser  <= user_out;
            m_axis_tlast  <= reach | s_axis_tlast;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end

         if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
            pkts_out <= pkts_out + 32'd1;
         if (fwd && cut)
            pkts_trunc <= pkts_trunc + 32'd1;

         if (accept && is_head) begin
            snap_q   <= rw_regs[15:0];
            active_q <= rw_regs[16] & (|rw_regs[15:0]);
         end

         if (fwd && !reach)
            cnt_q <= sum[15:0];

         if (accept) begin
            case (state)
               DROP:    state <= s_axis_tlast ? HEAD : DROP;
               default: begin
                  if (reach)
                     state <= s_axis_tlast ? HEAD : DROP;
                  else
                     state <= s_axis_tlast ? HEAD : BODY;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_capture_snaplen.sv
// Scoreboard bench for capture_snaplen: expected beats are queued as packets are
// driven and compared as the DUT hands them off.
module tb_capture_snaplen;

   logic         axi_aclk = 1'b0;
   logic         axi_reset;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tstrb;
   logic [127:0] s_axis_tuser;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic         s_axis_tlast;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tstrb;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic         m_axis_tlast;
   logic [31:0]  rw_regs;
   logic [31:0]  rw_defaults;
   logic [63:0]  ro_regs;

   capture_snaplen #(
      .C_M_AXIS_DATA_WIDTH(256),
      .C_S_AXIS_DATA_WIDTH(256),
      .C_M_AXIS_TUSER_WIDTH(128),
      .C_S_AXIS_TUSER_WIDTH(128),
      .C_S_AXI_DATA_WIDTH(32),
      .NUM_RW_REGS(1),
      .NUM_RO_REGS(2)
   ) dut (
      .axi_aclk(axi_aclk),
      .axi_reset(axi_reset),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tstrb(s_axis_tstrb),
      .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tstrb(m_axis_tstrb),
      .m_axis_tuser(m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .rw_regs(rw_regs),
      .rw_defaults(rw_defaults),
      .ro_regs(ro_regs)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  strb;
      logic [127:0] user;
      logic         last;
   } beat_t;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    exp_pkts = 0;
   int    exp_trunc = 0;
   logic  rand_ready = 1'b0;
   logic  fixed_ready = 1'b1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_n(input int n);
      if (n >= 32) return '1;
      return (32'h1 << n) - 32'h1;
   endfunction

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge axi_aclk);
         #1;
         m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
      end
   end

   // Output monitor: compare each handshake against the scoreboard, and require
   // a stalled beat to stay put until it is taken.
   logic         held = 1'b0;
   beat_t        held_b;
   always @(negedge axi_aclk) begin
      if (axi_reset) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", 256'(m_axis_tvalid), 256'(1));
            chk("stall_data", m_axis_tdata, held_b.data);
            chk("stall_strb", 256'(m_axis_tstrb), 256'(held_b.strb));
            chk("stall_user", 256'(m_axis_tuser), 256'(held_b.user));
            chk("stall_last", 256'(m_axis_tlast), 256'(held_b.last));
         end
         held = 1'b0;
         if (m_axis_tvalid) begin
            if (m_axis_tready) begin
               if (sb.size() == 0) begin
                  chk("extra_beat", 256'(sb.size()), 256'(1));
               end else begin
                  beat_t e;
                  e = sb.pop_front();
                  chk("out_data", m_axis_tdata, e.data);
                  chk("out_strb", 256'(m_axis_tstrb), 256'(e.strb));
                  chk("out_user", 256'(m_axis_tuser), 256'(e.user));
                  chk("out_last", 256'(m_axis_tlast), 256'(e.last));
               end
            end else begin
               held = 1'b1;
               held_b.data = m_axis_tdata;
               held_b.strb = m_axis_tstrb;
               held_b.user = m_axis_tuser;
               held_b.last = m_axis_tlast;
            end
         end
      end
   end

   task automatic wait_accept();
      logic rdy;
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge axi_aclk);
         rdy = s_axis_tready;
         @(posedge axi_aclk);
         #1;
         acc = rdy;
      end
      if (!acc) chk("accept_timeout", 256'(acc), 256'(1));
   endtask

   task automatic send_pkt(input int len, input logic [15:0] snap, input logic en,
                           input logic use_mid, input logic [31:0] mid_rw);
      int    nb, kept, bytes;
      logic  act, trunc;
      beat_t e;
      logic [255:0] data;
      logic [127:0] user;
      rw_regs = {15'b0, en, snap};
      act   = en && (snap != 16'd0);
      trunc = act && (int'(snap) < len);
      nb    = (len + 31) / 32;
      kept  = trunc ? (int'(snap) + 31) / 32 : nb;
      exp_pkts++;
      if (trunc) exp_trunc++;
      for (int i = 0; i < nb; i++) begin
         data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         user  = {$urandom, $urandom, $urandom, $urandom};
         bytes = (i == nb - 1) ? len - 32 * i : 32;
         if (i == 0) user[15:0] = len[15:0];
         if (i < kept) begin
            e.data = data;
            e.user = user;
            e.strb = mask_n(bytes);
            e.last = (i == nb - 1);
            if (i == 0 && act) e.user[15:0] = (len < int'(snap)) ? len[15:0] : snap;
            if (trunc && i == kept - 1) begin
               e.strb = mask_n(int'(snap) - 32 * i);
               e.last = 1'b1;
            end
            sb.push_back(e);
         end
         s_axis_tdata  = data;
         s_axis_tstrb  = mask_n(bytes);
         s_axis_tuser  = user;
         s_axis_tlast  = (i == nb - 1);
         s_axis_tvalid = 1'b1;
         wait_accept();
         if (i < kept) chk("latency", 256'(m_axis_tvalid), 256'(1));
         if (i == 0 && use_mid) rw_regs = mid_rw;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drain_and_check(input string tag);
      for (int t = 0; t < 2000; t++) begin
         if (sb.size() == 0 && !m_axis_tvalid) break;
         @(posedge axi_aclk);
         #1;
      end
      chk({tag, "_drain"}, 256'(sb.size()), 256'(0));
      chk({tag, "_pkts"}, 256'(ro_regs[31:0]), 256'(exp_pkts));
      chk({tag, "_trunc"}, 256'(ro_regs[63:32]), 256'(exp_trunc));
   endtask

   initial begin
      axi_reset     = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tstrb  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      rw_regs       = '0;
      repeat (3) @(posedge axi_aclk);
      #1;
      axi_reset = 1'b0;

      chk("rst_valid", 256'(m_axis_tvalid), 256'(0));
      chk("rst_data", m_axis_tdata, 256'(0));
      chk("rst_ro", 256'(ro_regs), 256'(0));
      chk("rw_defaults", 256'(rw_defaults), 256'(0));

      // disabled pass-through, then truncation at 64 and 40 with back-to-back heads
      send_pkt(100, 16'd0, 1'b0, 1'b0, '0);
      drain_and_check("passthru");
      send_pkt(100, 16'd64, 1'b1, 1'b0, '0);
      drain_and_check("snap64");
      send_pkt(100, 16'd40, 1'b1, 1'b0, '0);
      send_pkt(60, 16'd1500, 1'b1, 1'b0, '0);
      drain_and_check("snap40");

      // boundaries: exact fit, S=0, one spare byte, mid-packet register write
      send_pkt(64, 16'd64, 1'b1, 1'b0, '0);
      send_pkt(100, 16'd0, 1'b1, 1'b0, '0);
      send_pkt(33, 16'd32, 1'b1, 1'b0, '0);
      send_pkt(100, 16'd70, 1'b1, 1'b1, {15'b0, 1'b1, 16'd16});
      send_pkt(60, 16'd64, 1'b1, 1'b0, '0);
      drain_and_check("bounds");

      rand_ready = 1'b1;
      for (int p = 0; p < 20; p++) send_pkt(100, 16'd64, 1'b1, 1'b0, '0);
      drain_and_check("stall");
      rand_ready = 1'b0;

      // reset mid-packet while the first beat is stuck in the output register
      fixed_ready = 1'b0;
      @(posedge axi_aclk);
      #1;
      rw_regs       = {15'b0, 1'b1, 16'd64};
      s_axis_tdata  = {8{32'hDEADBEEF}};
      s_axis_tstrb  = '1;
      s_axis_tuser  = 128'd100;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b1;
      wait_accept();
      s_axis_tdata = {8{32'h12345678}};
      axi_reset    = 1'b1;
      @(posedge axi_aclk);
      #1;
      axi_reset     = 1'b0;
      s_axis_tvalid = 1'b0;
      chk("rst_mid_valid", 256'(m_axis_tvalid), 256'(0));
      chk("rst_mid_ro", 256'(ro_regs), 256'(0));
      exp_pkts  = 0;
      exp_trunc = 0;
      fixed_ready = 1'b1;
      send_pkt(60, 16'd64, 1'b1, 1'b0, '0);
      drain_and_check("after_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
